// File: rtl/alu_pkg.sv
// Shared ALU op encoding, RV32I opcodes and the issue payload struct.
// The ALU uses the same encoding.
package alu_pkg;

  localparam int unsigned ALU_N = 32;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_XOR = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_AND = 4'd4;
  localparam logic [3:0] ALU_SLL = 4'd5;
  localparam logic [3:0] ALU_SRL = 4'd6;
  localparam logic [3:0] ALU_SRA = 4'd7;
  localparam logic [3:0] ALU_SLT = 4'd8;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [3:0]       op;
    logic [ALU_N-1:0] a;
    logic [ALU_N-1:0] b;
    logic [4:0]       rd;
    logic             illegal;
  } issue_t;

endpackage

// File: rtl/alu_instr_decode.sv
// Combinational RV32I OP/OP-IMM decoder producing the ALU issue payload.
// Unsupported encodings become an illegal entry with op=ADD and rd=0.
module alu_instr_decode
  import alu_pkg::*;
(
  input  logic [31:0]      i_instr,
  input  logic [ALU_N-1:0] i_rs1_data,
  input  logic [ALU_N-1:0] i_rs2_data,
  output issue_t           o_issue
);

  logic [6:0]       w_opcode;
  logic [2:0]       w_f3;
  logic [6:0]       w_f7;
  logic [ALU_N-1:0] w_imm;
  logic [ALU_N-1:0] w_shamt;
  logic [3:0]       w_op;
  logic [ALU_N-1:0] w_b;
  logic             w_legal;
  logic             w_unused_rs1_idx;

  assign w_opcode = i_instr[6:0];
  assign w_f3     = i_instr[14:12];
  assign w_f7     = i_instr[31:25];
  assign w_imm    = {{(ALU_N-12){i_instr[31]}}, i_instr[31:20]};
  assign w_shamt  = {{(ALU_N-5){1'b0}}, i_instr[24:20]};

  // Register indices are resolved by the register-file read stage.
  assign w_unused_rs1_idx = ^i_instr[19:15];

  always_comb begin
    w_op    = ALU_ADD;
    w_b     = i_rs2_data;
    w_legal = 1'b0;
    case (w_opcode)
      OPC_OP: begin
        w_legal = (w_f7 == F7_BASE);
        unique case (w_f3)
          3'b000: begin
            w_op    = (w_f7 == F7_ALT) ? ALU_SUB : ALU_ADD;
            w_legal = (w_f7 == F7_BASE) || (w_f7 == F7_ALT);
          end
          3'b001: w_op = ALU_SLL;
          3'b010: w_op = ALU_SLT;
          3'b011: w_legal = 1'b0;
          3'b100: w_op = ALU_XOR;
          3'b101: begin
            w_op    = (w_f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
            w_legal = (w_f7 == F7_BASE) || (w_f7 == F7_ALT);
          end
          3'b110: w_op = ALU_OR;
          3'b111: w_op = ALU_AND;
        endcase
      end
      OPC_OPIMM: begin
        w_b     = w_imm;
        w_legal = 1'b1;
        unique case (w_f3)
          3'b000: w_op = ALU_ADD;
          3'b001: begin
            w_op    = ALU_SLL;
            w_b     = w_shamt;
            w_legal = (w_f7 == F7_BASE);
          end
          3'b010: w_op = ALU_SLT;
          3'b011: w_legal = 1'b0;
          3'b100: w_op = ALU_XOR;
          3'b101: begin
            w_op    = (w_f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
            w_b     = w_shamt;
            w_legal = (w_f7 == F7_BASE) || (w_f7 == F7_ALT);
          end
          3'b110: w_op = ALU_OR;
          3'b111: w_op = ALU_AND;
        endcase
      end
      default: w_legal = 1'b0;
    endcase
  end

  assign o_issue.op      = w_legal ? w_op : ALU_ADD;
  assign o_issue.a       = i_rs1_data;
  assign o_issue.b       = w_b;
  assign o_issue.rd      = w_legal ? i_instr[11:7] : 5'd0;
  assign o_issue.illegal = ~w_legal;

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes OP/OP-IMM and registers the payload behind a
// valid/ready handshake with a 2-entry main/skid buffer (registered in_ready).
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int unsigned N = ALU_N
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_flush,
  input  logic         i_in_valid,
  output logic         o_in_ready,
  input  logic [31:0]  i_instr,
  input  logic [N-1:0] i_rs1_data,
  input  logic [N-1:0] i_rs2_data,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic [3:0]   o_alu_operation,
  output logic [N-1:0] o_alu_a,
  output logic [N-1:0] o_alu_b,
  output logic [4:0]   o_rd,
  output logic         o_illegal
);

  // The payload struct is sized by the package; the two must agree.
  if (N != ALU_N) begin : g_bad_width
    $error("alu_issue_stage: N must equal alu_pkg::ALU_N");
  end

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e r_state;
  issue_t r_main;
  issue_t r_skid;
  logic   r_out_valid;
  logic   r_in_ready;
  issue_t w_dec;
  logic   w_in_fire;
  logic   w_out_fire;

  alu_instr_decode u_decode (
    .i_instr    (i_instr),
    .i_rs1_data (i_rs1_data),
    .i_rs2_data (i_rs2_data),
    .o_issue    (w_dec)
  );

  assign w_in_fire  = i_in_valid & r_in_ready;
  assign w_out_fire = r_out_valid & i_out_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StEmpty;
      r_main      <= '0;
      r_skid      <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else if (i_flush) begin
      // Flush drops the input; an output handshake this cycle has already completed.
      r_state     <= StEmpty;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      unique case (r_state)
        StEmpty: begin
          if (w_in_fire) begin
            r_main      <= w_dec;
            r_state     <= StOne;
            r_out_valid <= 1'b1;
          end
        end
        StOne: begin
          if (w_in_fire && w_out_fire) begin
            r_main <= w_dec;
          end else if (w_in_fire) begin
            r_skid     <= w_dec;
            r_state    <= StTwo;
            r_in_ready <= 1'b0;
          end else if (w_out_fire) begin
            r_state     <= StEmpty;
            r_out_valid <= 1'b0;
          end
        end
        StTwo: begin
          if (w_out_fire) begin
            r_main     <= r_skid;
            r_state    <= StOne;
            r_in_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= StEmpty;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign o_in_ready      = r_in_ready;
  assign o_out_valid     = r_out_valid;
  assign o_alu_operation = r_main.op;
  assign o_alu_a         = r_main.a;
  assign o_alu_b         = r_main.b;
  assign o_rd            = r_main.rd;
  assign o_illegal       = r_main.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed and scoreboard-driven checks of alu_issue_stage decode, skid buffering,
// flush and reset.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [4:0]  rd;
  logic        illegal;

  int n_pass = 0;
  int n_total = 0;

  alu_issue_stage #(.N(32)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_flush         (flush),
    .i_in_valid      (in_valid),
    .o_in_ready      (in_ready),
    .i_instr         (instr),
    .i_rs1_data      (rs1),
    .i_rs2_data      (rs2),
    .o_out_valid     (out_valid),
    .i_out_ready     (out_ready),
    .o_alu_operation (alu_op),
    .o_alu_a         (alu_a),
    .o_alu_b         (alu_b),
    .o_rd            (rd),
    .o_illegal       (illegal)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    instr = 32'h0; rs1 = 32'h0; rs2 = 32'h0;
    tick();
    tick();
    rst = 1'b0;
    n_total++;
    if ({out_valid, in_ready, alu_op, alu_a, alu_b, rd, illegal} !==
        {1'b0, 1'b1, 4'd0, 32'd0, 32'd0, 5'd0, 1'b0})
      $display("FAIL reset: got v=%b rdy=%b op=%0d a=%h b=%h rd=%0d ill=%b, want 0 1 0 0 0 0 0",
               out_valid, in_ready, alu_op, alu_a, alu_b, rd, illegal);
    else n_pass++;
  endtask

  typedef struct {
    logic [31:0] ins;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [3:0]  op;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        ill;
  } vec_t;

  task automatic test_decode();
    vec_t v[13];
    v[0]  = '{32'h002081B3, 32'd5,  32'd7,  4'd0, 32'd7,        5'd3,  1'b0}; // ADD
    v[1]  = '{32'h402081B3, 32'd9,  32'd4,  4'd1, 32'd4,        5'd3,  1'b0}; // SUB
    v[2]  = '{32'hFFF00093, 32'd0,  32'h55, 4'd0, 32'hFFFFFFFF, 5'd1,  1'b0}; // ADDI -1
    v[3]  = '{32'h4040D113, 32'hF0, 32'h99, 4'd7, 32'd4,        5'd2,  1'b0}; // SRAI
    v[4]  = '{32'h0020B1B3, 32'd1,  32'd2,  4'd0, 32'd0,        5'd0,  1'b1}; // SLTU
    v[5]  = '{32'h007342B3, 32'hA5, 32'h5A, 4'd2, 32'h5A,       5'd5,  1'b0}; // XOR
    v[6]  = '{32'h01F09213, 32'd3,  32'd8,  4'd5, 32'd31,       5'd4,  1'b0}; // SLLI 31
    v[7]  = '{32'h40309213, 32'd3,  32'd8,  4'd0, 32'd0,        5'd0,  1'b1}; // SLLI bad f7
    v[8]  = '{32'h7F00F413, 32'd6,  32'd1,  4'd4, 32'h7F0,      5'd8,  1'b0}; // ANDI
    v[9]  = '{32'h0020A533, 32'd2,  32'd3,  4'd8, 32'd3,        5'd10, 1'b0}; // SLT
    v[10] = '{32'h12345037, 32'd2,  32'd3,  4'd0, 32'd0,        5'd0,  1'b1}; // LUI
    v[11] = '{32'h003150B3, 32'd7,  32'd1,  4'd6, 32'd1,        5'd1,  1'b0}; // SRL
    v[12] = '{32'h003160B3, 32'd7,  32'd9,  4'd3, 32'd9,        5'd1,  1'b0}; // OR
    out_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      instr = v[i].ins; rs1 = v[i].s1; rs2 = v[i].s2; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      n_total++;
      if ({out_valid, alu_op, alu_a, rd, illegal} !== {1'b1, v[i].op, v[i].s1, v[i].rd, v[i].ill})
        $display("FAIL decode[%0d]: got v=%b op=%0d a=%h rd=%0d ill=%b, want 1 %0d %h %0d %b",
                 i, out_valid, alu_op, alu_a, rd, illegal, v[i].op, v[i].s1, v[i].rd, v[i].ill);
      else n_pass++;
      if (!v[i].ill) begin
        n_total++;
        if (alu_b !== v[i].b) $display("FAIL decode_b[%0d]: got %h want %h", i, alu_b, v[i].b);
        else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ins[3];
    logic [31:0] dat[3];
    ins[0] = 32'h002080B3; ins[1] = 32'h00208133; ins[2] = 32'h002081B3;
    dat[0] = 32'h11; dat[1] = 32'h22; dat[2] = 32'h33;
    out_ready = 1'b0;
    rs2 = 32'h0;
    instr = ins[0]; rs1 = dat[0]; in_valid = 1'b1;
    tick();
    n_total++;
    if ({out_valid, in_ready, rd, alu_a} !== {1'b1, 1'b1, 5'd1, dat[0]})
      $display("FAIL bp_a: got v=%b rdy=%b rd=%0d a=%h want 1 1 1 11", out_valid, in_ready, rd, alu_a);
    else n_pass++;
    instr = ins[1]; rs1 = dat[1];
    tick();
    n_total++;
    if ({out_valid, in_ready, rd} !== {1'b1, 1'b0, 5'd1})
      $display("FAIL bp_full: got v=%b rdy=%b rd=%0d want 1 0 1", out_valid, in_ready, rd);
    else n_pass++;
    instr = ins[2]; rs1 = dat[2];
    tick();
    tick();
    n_total++;
    if ({out_valid, in_ready, rd, alu_a} !== {1'b1, 1'b0, 5'd1, dat[0]})
      $display("FAIL bp_hold: got v=%b rdy=%b rd=%0d a=%h want 1 0 1 11", out_valid, in_ready, rd, alu_a);
    else n_pass++;
    out_ready = 1'b1;
    tick();
    n_total++;
    if ({out_valid, in_ready, rd, alu_a} !== {1'b1, 1'b1, 5'd2, dat[1]})
      $display("FAIL bp_b: got v=%b rdy=%b rd=%0d a=%h want 1 1 2 22", out_valid, in_ready, rd, alu_a);
    else n_pass++;
    tick();
    in_valid = 1'b0;
    n_total++;
    if ({out_valid, rd, alu_a} !== {1'b1, 5'd3, dat[2]})
      $display("FAIL bp_c: got v=%b rd=%0d a=%h want 1 3 33", out_valid, rd, alu_a);
    else n_pass++;
    tick();
    n_total++;
    if ({out_valid, in_ready} !== 2'b01)
      $display("FAIL bp_drain: got v=%b rdy=%b want 0 1", out_valid, in_ready);
    else n_pass++;
  endtask

  task automatic fill_two();
    out_ready = 1'b0;
    instr = 32'h402081B3; rs1 = 32'hDEAD; rs2 = 32'hBEEF; in_valid = 1'b1;
    tick();
    instr = 32'h00208133;
    tick();
  endtask

  task automatic test_flush();
    fill_two();
    n_total++;
    if (in_ready !== 1'b0) $display("FAIL flush_pre: in_ready got %b want 0", in_ready);
    else n_pass++;
    instr = 32'h002080B3; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    n_total++;
    if ({out_valid, in_ready} !== 2'b01)
      $display("FAIL flush: got v=%b rdy=%b want 0 1", out_valid, in_ready);
    else n_pass++;
    out_ready = 1'b1;
    tick();
    tick();
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL flush_drop: out_valid got %b want 0", out_valid);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    fill_two();
    rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    n_total++;
    if ({out_valid, in_ready, alu_op, alu_a, alu_b, rd, illegal} !==
        {1'b0, 1'b1, 4'd0, 32'd0, 32'd0, 5'd0, 1'b0})
      $display("FAIL reset_mid: got v=%b rdy=%b op=%0d a=%h b=%h rd=%0d ill=%b, want 0 1 0 0 0 0 0",
               out_valid, in_ready, alu_op, alu_a, alu_b, rd, illegal);
    else n_pass++;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [4:0]  rd;
  } exp_t;

  task automatic test_random();
    exp_t q[$];
    exp_t e;
    logic in_f;
    logic out_f;
    int   errs;
    errs = 0;
    for (int c = 0; c < 300; c++) begin
      n_total++;
      if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2) ||
          (q.size() > 0 && (alu_a !== q[0].a || rd !== q[0].rd))) begin
        if (errs < 5)
          $display("FAIL random[%0d]: got v=%b rdy=%b a=%h rd=%0d want v=%0d rdy=%0d a=%h rd=%0d",
                   c, out_valid, in_ready, alu_a, rd, q.size() > 0, q.size() < 2,
                   q.size() > 0 ? q[0].a : 32'h0, q.size() > 0 ? q[0].rd : 5'd0);
        errs++;
      end else n_pass++;
      e.rd = 5'($urandom_range(1, 31));
      e.a  = $urandom;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      instr = {7'b0, 5'd2, 5'd1, 3'b000, e.rd, 7'b0110011};
      rs1 = e.a; rs2 = $urandom;
      in_f  = in_valid && (q.size() < 2);
      out_f = (q.size() > 0) && out_ready;
      if (flush) q.delete();
      else begin
        if (out_f) void'(q.pop_front());
        if (in_f) q.push_back(e);
      end
      tick();
    end
    in_valid = 1'b0; flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_decode();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
